// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle for fetch_decode_queue: fetch push side, decode pop side, status.
// The master modport is the fetch+decode environment; the slave modport is the queue.
interface fetch_decode_queue_if #(
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic [15:0]   in_instr;
    logic [15:0]   in_pc_plus_two;
    logic          in_err;
    logic          in_ready;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [15:0]   out_instr;
    logic [15:0]   out_pc_plus_two;
    logic          out_err;
    logic [CW-1:0] count;
    logic          halt_seen;
    logic          err;

    modport master (
        output in_valid, in_instr, in_pc_plus_two, in_err, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc_plus_two, out_err, count, halt_seen, err
    );

    modport slave (
        input  in_valid, in_instr, in_pc_plus_two, in_err, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc_plus_two, out_err, count, halt_seen, err
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular instruction queue between fetch and decode: NOP when empty, flush on redirect, freeze after HALT.
// Optional FDQ_BYPASS_EN: an empty queue forwards the fetched instruction to decode in the same cycle.
module fetch_decode_queue #(
    parameter int unsigned DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    fetch_decode_queue_if.slave q
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [15:0] NOP = 16'h0800;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus_two;
        logic        err;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            halt_seen_q, halt_seen_d;
    logic            err_q, err_d;

    logic in_ready_c, head_valid_c, push_c, pop_c, store_c, bypass_c, is_halt_c;

    // Handshake qualifiers; in_ready never looks at out_ready.
    always_comb begin
        in_ready_c   = (count_q < CW'(DEPTH)) & ~halt_seen_q & ~q.flush;
        head_valid_c = (count_q != '0);
        push_c       = q.in_valid & in_ready_c;
        pop_c        = head_valid_c & q.out_ready;
        is_halt_c    = (q.in_instr[15:11] == 5'b00000);
`ifdef FDQ_BYPASS_EN
        bypass_c     = ~head_valid_c & push_c;
        store_c      = push_c & ~(bypass_c & q.out_ready);
`else
        bypass_c     = 1'b0;
        store_c      = push_c;
`endif
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        halt_seen_d = halt_seen_q;
        err_d       = err_q;
        count_d     = count_q + CW'(store_c) - CW'(pop_c);
        if (store_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_c)   rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_c && is_halt_c) halt_seen_d = 1'b1;
        if (q.in_valid && !in_ready_c && !halt_seen_q && !q.flush) err_d = 1'b1;
        // Redirect: a same-cycle pop has already been handed to decode, nothing else survives.
        if (q.flush) begin
            count_d     = '0;
            rd_ptr_d    = wr_ptr_q;
            halt_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (store_c) mem_q[wr_ptr_q] <= '{instr: q.in_instr, pc_plus_two: q.in_pc_plus_two, err: q.in_err};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            halt_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            halt_seen_q <= halt_seen_d;
            err_q       <= err_d;
        end
    end

    // Decode sees the bypassed input, the stored head, or a NOP bubble.
    always_comb begin
        q.out_valid       = 1'b0;
        q.out_instr       = NOP;
        q.out_pc_plus_two = 16'h0000;
        q.out_err         = 1'b0;
        if (bypass_c) begin
            q.out_valid       = 1'b1;
            q.out_instr       = q.in_instr;
            q.out_pc_plus_two = q.in_pc_plus_two;
            q.out_err         = q.in_err;
        end else if (head_valid_c) begin
            q.out_valid       = 1'b1;
            q.out_instr       = mem_q[rd_ptr_q].instr;
            q.out_pc_plus_two = mem_q[rd_ptr_q].pc_plus_two;
            q.out_err         = mem_q[rd_ptr_q].err;
        end
        q.in_ready  = in_ready_c;
        q.count     = count_q;
        q.halt_seen = halt_seen_q;
        q.err       = err_q;
    end
endmodule
